// File: rtl/wb_pkg.sv
// Shared select encodings, entry layout and register-index helper for the
// write-back stage buffer.
package wb_pkg;

    localparam logic [1:0] REG_SEL_MEM   = 2'd0;
    localparam logic [1:0] REG_SEL_ALU   = 2'd1;
    localparam logic [1:0] REG_SEL_IMM   = 2'd2;
    localparam logic [1:0] REG_SEL_PCINC = 2'd3;

    localparam logic [1:0] R7_SEL_IMM    = 2'd0;
    localparam logic [1:0] R7_SEL_MEM    = 2'd1;
    localparam logic [1:0] R7_SEL_PCIMM  = 2'd2;
    localparam logic [1:0] R7_SEL_ALU    = 2'd3;

    localparam int unsigned WB_DATA_W = 16;
    localparam int unsigned WB_NREG   = 8;
    localparam int unsigned WB_RD_W   = $clog2(WB_NREG);

    // Buffered entry at the default core configuration; the top re-declares
    // the same field order sized from its own parameters.
    typedef struct packed {
        logic [WB_RD_W-1:0]   rd;
        logic                 reg_we;
        logic                 r7_we;
        logic [WB_DATA_W-1:0] wdata;
        logic [WB_DATA_W-1:0] r7data;
    } wb_entry_t;

    function automatic int unsigned r7_index(input int unsigned nreg);
        return nreg - 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic in-order synchronous FIFO; push and pop may coincide when full.
// With WB_STAGE_BUF_FWD_EN defined, exposes entries oldest-first for lookup.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full
`ifdef WB_STAGE_BUF_FWD_EN
    ,
    output logic [DEPTH-1:0][WIDTH-1:0]  ordered,
    output logic [DEPTH-1:0]             live
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

`ifdef WB_STAGE_BUF_FWD_EN
    always_comb begin
        ordered = '0;
        live    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ordered[i] = mem[PTR_W'(rptr + PTR_W'(i))];
            live[i]    = (CNT_W'(i) < count);
        end
    end
`endif

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage: resolves MEM results at enqueue, buffers them in order and
// drains into the register file ports. WB_STAGE_BUF_FWD_EN adds a bypass lookup.
module wb_stage_buf
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [DATA_W-1:0]         in_mem,
    input  logic [DATA_W-1:0]         in_pcimm,
    input  logic [DATA_W-1:0]         in_alu,
    input  logic [DATA_W-1:0]         in_pcinc,
    input  logic [1:0]                in_reg_sel,
    input  logic [1:0]                in_r7_sel,
    input  logic [$clog2(NREG)-1:0]   in_rd,
    input  logic                      in_reg_we,
    input  logic                      in_r7_we,
    input  logic                      rf_ready,
    output logic                      rf_we,
    output logic [$clog2(NREG)-1:0]   rf_addr,
    output logic [DATA_W-1:0]         rf_data,
    output logic                      r7_we,
    output logic [DATA_W-1:0]         r7_data,
    output logic [CNT_W-1:0]          retire_count
`ifdef WB_STAGE_BUF_FWD_EN
    ,
    input  logic [$clog2(NREG)-1:0]   fwd_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data
`endif
);

    localparam int unsigned RD_W = $clog2(NREG);
    localparam logic [RD_W-1:0] R7 = RD_W'(r7_index(NREG));

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic              reg_we;
        logic              r7_we;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] r7data;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t            enq;
    entry_t            head;
    logic [ENTRY_W-1:0] head_raw;
    logic              fire;
    logic              pop;
    logic              empty;
    logic              full;
    logic              nonempty;

    // Both data muxes resolve at enqueue so the buffer holds final write data.
    always_comb begin
        enq        = '0;
        enq.rd     = in_rd;
        enq.reg_we = in_reg_we;
        enq.r7_we  = in_r7_we;
        case (in_reg_sel)
            REG_SEL_MEM:   enq.wdata = in_mem;
            REG_SEL_ALU:   enq.wdata = in_alu;
            REG_SEL_IMM:   enq.wdata = in_imm;
            default:       enq.wdata = in_pcinc;
        endcase
        case (in_r7_sel)
            R7_SEL_IMM:    enq.r7data = in_imm;
            R7_SEL_MEM:    enq.r7data = in_mem;
            R7_SEL_PCIMM:  enq.r7data = in_pcimm;
            default:       enq.r7data = in_alu;
        endcase
    end

    assign in_ready = ~full | rf_ready;
    assign fire     = in_valid & in_ready;
    assign nonempty = ~empty;
    assign pop      = nonempty & rf_ready;

`ifdef WB_STAGE_BUF_FWD_EN
    logic [DEPTH-1:0][ENTRY_W-1:0] ordered;
    logic [DEPTH-1:0]              live;
`endif

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fire),
        .din     (enq),
        .pop     (pop),
        .dout    (head_raw),
        .empty   (empty),
        .full    (full)
`ifdef WB_STAGE_BUF_FWD_EN
        ,
        .ordered (ordered),
        .live    (live)
`endif
    );

    assign head = entry_t'(head_raw);

    // Data outputs are zeroed while empty so stale storage never leaks out.
    assign rf_addr = nonempty ? head.rd     : '0;
    assign rf_data = nonempty ? head.wdata  : '0;
    assign r7_data = nonempty ? head.r7data : '0;

    // A double write to R7 goes through the R7 port only.
    assign rf_we = pop & head.reg_we & ~(head.r7_we & (head.rd == R7));
    assign r7_we = pop & head.r7_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (pop) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

`ifdef WB_STAGE_BUF_FWD_EN
    // Oldest-to-newest scan so the newest matching entry wins.
    always_comb begin
        entry_t e;
        e        = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = entry_t'(ordered[i]);
            if (live[i] && e.r7_we && (fwd_addr == R7)) begin
                fwd_hit  = 1'b1;
                fwd_data = e.r7data;
            end else if (live[i] && e.reg_we && (e.rd == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = e.wdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: driver enqueues hand-computed expectations,
// monitor compares the head/strobes every cycle against the queue.
module tb_wb_stage_buf;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RD_W   = 3;

    typedef struct packed {
        logic              gwe;
        logic [RD_W-1:0]   addr;
        logic [DATA_W-1:0] data;
        logic              r7we;
        logic [DATA_W-1:0] r7data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_imm, in_mem, in_pcimm, in_alu, in_pcinc;
    logic [1:0]        in_reg_sel, in_r7_sel;
    logic [RD_W-1:0]   in_rd;
    logic              in_reg_we, in_r7_we;
    logic              rf_ready;
    logic              rf_we;
    logic [RD_W-1:0]   rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              r7_we;
    logic [DATA_W-1:0] r7_data;
    logic [CNT_W-1:0]  retire_count;
`ifdef WB_STAGE_BUF_FWD_EN
    logic [RD_W-1:0]   fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    exp_t        drv_exp;
    logic [3:0]  exp_retire = 4'd0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    wb_stage_buf #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_mem       (in_mem),
        .in_pcimm     (in_pcimm),
        .in_alu       (in_alu),
        .in_pcinc     (in_pcinc),
        .in_reg_sel   (in_reg_sel),
        .in_r7_sel    (in_r7_sel),
        .in_rd        (in_rd),
        .in_reg_we    (in_reg_we),
        .in_r7_we     (in_r7_we),
        .rf_ready     (rf_ready),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .r7_we        (r7_we),
        .r7_data      (r7_data),
        .retire_count (retire_count)
`ifdef WB_STAGE_BUF_FWD_EN
        ,
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endfunction

    // Scoreboard update: the pop uses the pre-edge queue, then a fire appends.
    always @(posedge clk) begin
        exp_t tmp;
        logic fire;
        fire = in_valid && in_ready;
        if (!reset) begin
            q.delete();
            exp_retire = 4'd0;
        end else begin
            if (q.size() > 0 && rf_ready) begin
                tmp = q.pop_front();
                exp_retire = exp_retire + 4'd1;
            end
            if (fire) q.push_back(drv_exp);
        end
    end

    // Monitor: mid-cycle compare of every output against the queue head.
    always @(negedge clk) begin
        exp_t h;
        logic ne;
        if (mon_en) begin
            ne = (q.size() > 0);
            h  = ne ? q[0] : '0;
            chk("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) || rf_ready));
            chk("rf_we", 32'(rf_we), 32'(ne & h.gwe & rf_ready));
            chk("r7_we", 32'(r7_we), 32'(ne & h.r7we & rf_ready));
            chk("rf_addr", 32'(rf_addr), 32'(h.addr));
            chk("rf_data", 32'(rf_data), 32'(h.data));
            chk("r7_data", 32'(r7_data), 32'(h.r7data));
            chk("retire_count", 32'(retire_count), 32'(exp_retire));
        end
    end

    task automatic set_src(input logic [15:0] imm, input logic [15:0] mem,
                           input logic [15:0] pcimm, input logic [15:0] alu,
                           input logic [15:0] pcinc);
        in_imm = imm; in_mem = mem; in_pcimm = pcimm; in_alu = alu; in_pcinc = pcinc;
    endtask

    task automatic send(input logic [1:0] rsel, input logic [1:0] r7sel, input logic [2:0] rd,
                        input logic rwe, input logic r7w, input logic egwe,
                        input logic [15:0] edata, input logic er7we, input logic [15:0] er7data);
        logic ok;
        int   n;
        in_reg_sel = rsel; in_r7_sel = r7sel; in_rd = rd;
        in_reg_we = rwe; in_r7_we = r7w;
        drv_exp = '{gwe: egwe, addr: rd, data: edata, r7we: er7we, r7data: er7data};
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for rd=%0d", rd);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries still pending", q.size());
        end
    endtask

    initial begin
        reset = 1'b0; rf_ready = 1'b1; in_valid = 1'b0;
        in_reg_sel = 2'd0; in_r7_sel = 2'd0; in_rd = '0; in_reg_we = 1'b0; in_r7_we = 1'b0;
        set_src(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055);
`ifdef WB_STAGE_BUF_FWD_EN
        fwd_addr = '0;
`endif
        @(posedge clk); #1 mon_en = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_retire", 32'(retire_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Single ALU write
        set_src(16'h0011, 16'h0022, 16'h0033, 16'h1234, 16'h0055);
        send(2'd1, 2'd0, 3'd3, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0011);
        wait_drain();
        chk("alu_retire", 32'(retire_count), 32'd1);

        // Back-pressure: third fire coincides with the first pop
        set_src(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055);
        rf_ready = 1'b0;
        send(2'd0, 2'd3, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b0, 16'h0044);
        send(2'd2, 2'd1, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0022);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        fork
            send(2'd3, 2'd2, 3'd4, 1'b1, 1'b1, 1'b1, 16'h0055, 1'b1, 16'h0033);
            begin
                repeat (3) @(posedge clk);
                #1 rf_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_retire", 32'(retire_count), 32'd4);

        // R7 conflict, R7 via general port, R7-only write
        set_src(16'h0011, 16'h0022, 16'h0040, 16'h0044, 16'h0055);
        send(2'd1, 2'd2, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0044, 1'b1, 16'h0040);
        send(2'd2, 2'd0, 3'd7, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0011);
        send(2'd0, 2'd1, 3'd5, 1'b0, 1'b1, 1'b0, 16'h0022, 1'b1, 16'h0022);
        wait_drain();

        // Bubble still retires
        set_src(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055);
        send(2'd3, 2'd3, 3'd6, 1'b0, 1'b0, 1'b0, 16'h0055, 1'b0, 16'h0044);
        wait_drain();
        chk("bubble_retire", 32'(retire_count), 32'd8);

        // Reset mid-drain discards buffered entries
        rf_ready = 1'b0;
        send(2'd1, 2'd0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0044, 1'b0, 16'h0011);
        send(2'd0, 2'd1, 3'd2, 1'b1, 1'b1, 1'b1, 16'h0022, 1'b1, 16'h0022);
        chk("rst_mid_full", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        chk("rst_mid_rf_we", 32'(rf_we), 32'd0);
        chk("rst_mid_r7_we", 32'(r7_we), 32'd0);
        chk("rst_mid_addr", 32'(rf_addr), 32'd0);
        chk("rst_mid_data", 32'(rf_data), 32'd0);
        chk("rst_mid_r7data", 32'(r7_data), 32'd0);
        chk("rst_mid_retire", 32'(retire_count), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        rf_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_mid_no_commit", 32'(retire_count), 32'd0);

        // Retire counter wrap at 2^CNT_W
        for (int i = 0; i < 15; i++)
            send(2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0022, 1'b0, 16'h0011);
        wait_drain();
        chk("wrap_15", 32'(retire_count), 32'd15);
        send(2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0022, 1'b0, 16'h0011);
        wait_drain();
        chk("wrap_0", 32'(retire_count), 32'd0);

`ifdef WB_STAGE_BUF_FWD_EN
        // Forwarding picks the newest pending write
        rf_ready = 1'b0;
        set_src(16'h0011, 16'h0022, 16'h0033, 16'hAAAA, 16'h0055);
        send(2'd1, 2'd0, 3'd2, 1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0011);
        set_src(16'h0011, 16'h0022, 16'h0033, 16'hBBBB, 16'h0055);
        send(2'd1, 2'd0, 3'd2, 1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b0, 16'h0011);
        fwd_addr = 3'd2;
        #1 chk("fwd_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_data", 32'(fwd_data), 32'h0000BBBB);
        fwd_addr = 3'd3;
        #1 chk("fwd_miss", 32'(fwd_hit), 32'd0);
        rf_ready = 1'b1;
        wait_drain();
        fwd_addr = 3'd2;
        #1 chk("fwd_empty", 32'(fwd_hit), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
